// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake movement scheduler.
package snake_pkg;

    localparam int unsigned DIR_W = 2;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd1;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd2;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    // Opposite direction: up<->down, right<->left (flip bit 1 of the encoding).
    function automatic logic [DIR_W-1:0] opposite(input logic [DIR_W-1:0] d);
        return d ^ 2'd2;
    endfunction

    // Column delta of a direction as a signed 2-bit step.
    function automatic logic signed [1:0] dx(input logic [DIR_W-1:0] d);
        case (d)
            DIR_RIGHT: return 2'sd1;
            DIR_LEFT:  return -2'sd1;
            default:   return 2'sd0;
        endcase
    endfunction

    // Row delta of a direction as a signed 2-bit step (row 0 is the top).
    function automatic logic signed [1:0] dy(input logic [DIR_W-1:0] d);
        case (d)
            DIR_DOWN: return 2'sd1;
            DIR_UP:   return -2'sd1;
            default:  return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/snake_frame_div.sv
// Frame-tick divider: counts ticks while enabled and flags the tick that completes a step period.
module snake_frame_div #(
    parameter int unsigned FRAMES_PER_STEP = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic tick_i,
    output logic step_due_o
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES_PER_STEP - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Combinational due flag: valid on the same cycle as the completing tick.
    assign step_due_o = tick_i && (cnt_q == LAST);

    // Next count: clear wins, otherwise advance on tick and wrap at the period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = step_due_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake head movement scheduler: game FSM, direction filter and head datapath.
// Optional feature macro: WRAP_EN (walls wrap around instead of killing the snake).
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W          = 32,
    parameter int unsigned GRID_H          = 24,
    parameter int unsigned CW              = 6,
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned START_X         = 16,
    parameter int unsigned START_Y         = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          start,
    input  logic [1:0]    dir_req,
    input  logic          dir_valid,
    output logic [CW-1:0] head_x,
    output logic [CW-1:0] head_y,
    output logic [1:0]    dir,
    output logic          step,
    output logic          running,
    output logic          dead
);

    localparam logic [CW-1:0] X_MAX  = CW'(GRID_W - 1);
    localparam logic [CW-1:0] Y_MAX  = CW'(GRID_H - 1);
    localparam logic [CW-1:0] X_INIT = CW'(START_X);
    localparam logic [CW-1:0] Y_INIT = CW'(START_Y);

    state_e        state_q, state_d;
    logic [CW-1:0] head_x_q, head_x_d;
    logic [CW-1:0] head_y_q, head_y_d;
    logic [1:0]    dir_q, dir_d;
    logic [1:0]    pend_q, pend_d;
    logic          step_q, step_d;
    logic          running_q, running_d;
    logic          dead_q, dead_d;

    logic          in_run;
    logic          step_due;
    logic [1:0]    ref_dir;
    logic          hit_x;
    logic          hit_y;
    logic [CW-1:0] next_x;
    logic [CW-1:0] next_y;

    assign in_run = (state_q == ST_RUN);

    snake_frame_div #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_frame_div (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (!in_run),
        .tick_i     (frame_tick && in_run),
        .step_due_o (step_due)
    );

    // Wall test and candidate next cell for the pending direction.
    always_comb begin
        hit_x  = ((pend_q == DIR_RIGHT) && (head_x_q == X_MAX)) ||
                 ((pend_q == DIR_LEFT)  && (head_x_q == '0));
        hit_y  = ((pend_q == DIR_DOWN)  && (head_y_q == Y_MAX)) ||
                 ((pend_q == DIR_UP)    && (head_y_q == '0));
        next_x = head_x_q + CW'(dx(pend_q));
        next_y = head_y_q + CW'(dy(pend_q));
`ifdef WRAP_EN
        if (hit_x) begin
            next_x = (pend_q == DIR_RIGHT) ? '0 : X_MAX;
        end
        if (hit_y) begin
            next_y = (pend_q == DIR_DOWN) ? '0 : Y_MAX;
        end
`endif
    end

    // Next-state, direction filter and head update.
    always_comb begin
        state_d  = state_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        step_d   = 1'b0;
        ref_dir  = step_due ? pend_q : dir_q;

        case (state_q)
            ST_IDLE, ST_DEAD: begin
                if (start) begin
                    state_d  = ST_RUN;
                    head_x_d = X_INIT;
                    head_y_d = Y_INIT;
                    dir_d    = DIR_RIGHT;
                    pend_d   = DIR_RIGHT;
                end
            end
            ST_RUN: begin
                // A request is judged against the direction in force after this cycle.
                if (dir_valid && (dir_req != opposite(ref_dir))) begin
                    pend_d = dir_req;
                end
                if (step_due) begin
                    dir_d = pend_q;
`ifdef WRAP_EN
                    head_x_d = next_x;
                    head_y_d = next_y;
                    step_d   = 1'b1;
`else
                    if (hit_x || hit_y) begin
                        state_d = ST_DEAD;
                    end else begin
                        head_x_d = next_x;
                        head_y_d = next_y;
                        step_d   = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUN);
        dead_d    = (state_d == ST_DEAD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            head_x_q  <= X_INIT;
            head_y_q  <= Y_INIT;
            dir_q     <= DIR_RIGHT;
            pend_q    <= DIR_RIGHT;
            step_q    <= 1'b0;
            running_q <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_x_q  <= head_x_d;
            head_y_q  <= head_y_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            step_q    <= step_d;
            running_q <= running_d;
            dead_q    <= dead_d;
        end
    end

    assign head_x  = head_x_q;
    assign head_y  = head_y_q;
    assign dir     = dir_q;
    assign step    = step_q;
    assign running = running_q;
    assign dead    = dead_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Self-checking bench for snake_step_ctrl: directed scenarios plus random play
// against a cell-level reference model with a step scoreboard.
module tb_snake_step_ctrl;

    localparam int GW  = 32;
    localparam int GH  = 24;
    localparam int FPS = 4;
    localparam int SX  = 16;
    localparam int SY  = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic       dir_valid = 1'b0;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic [1:0] dir;
    logic       step;
    logic       running;
    logic       dead;

    always #5 clk = ~clk;

    snake_step_ctrl #(
        .GRID_W          (GW),
        .GRID_H          (GH),
        .CW              (6),
        .FRAMES_PER_STEP (FPS),
        .START_X         (SX),
        .START_Y         (SY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .dir_req    (dir_req),
        .dir_valid  (dir_valid),
        .head_x     (head_x),
        .head_y     (head_y),
        .dir        (dir),
        .step       (step),
        .running    (running),
        .dead       (dead)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int x;
        int y;
        int d;
    } step_t;
    step_t exp_q[$];

    // Reference model: 0 idle, 1 run, 2 dead
    int m_state = 0;
    int m_x = SX, m_y = SY, m_dir = 1, m_pend = 1, m_frames = 0;
    bit m_step = 1'b0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_restart();
        m_x = SX; m_y = SY; m_dir = 1; m_pend = 1; m_frames = 0;
    endtask

    // Effect of one clock edge on the model, given the inputs about to be sampled.
    task automatic model_edge(input bit r, input bit s, input bit t, input bit v, input int d);
        int nx, ny, refd;
        bit due;
        m_step = 1'b0;
        if (r) begin
            m_state = 0;
            model_restart();
            exp_q.delete();
            return;
        end
        if (m_state != 1) begin
            if (s) begin
                m_state = 1;
                model_restart();
            end
            return;
        end
        due = t && (m_frames + 1 == FPS);
        if (t) m_frames = due ? 0 : m_frames + 1;
        refd = due ? m_pend : m_dir;
        if (due) begin
            nx = m_x + ((m_pend == 1) ? 1 : (m_pend == 3) ? -1 : 0);
            ny = m_y + ((m_pend == 2) ? 1 : (m_pend == 0) ? -1 : 0);
            m_dir = m_pend;
            if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
                m_x = nx; m_y = ny; m_step = 1'b1;
            end else begin
`ifdef WRAP_EN
                m_x = (nx + GW) % GW; m_y = (ny + GH) % GH; m_step = 1'b1;
`else
                m_state = 2;
                m_frames = 0;
`endif
            end
            if (m_step) exp_q.push_back('{m_x, m_y, m_dir});
        end
        if (v && d != ((refd + 2) % 4)) m_pend = d;
    endtask

    // Drive one cycle at the falling edge; returns shortly after the rising edge.
    task automatic cyc(input bit r, input bit s, input bit t, input bit v, input int d);
        @(negedge clk);
        rst = r; start = s; frame_tick = t; dir_valid = v; dir_req = 2'(d);
        model_edge(r, s, t, v, d);
        mon_en = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0);
    endtask

    // n head steps, each FPS ticks separated by idle cycles.
    task automatic steps(input int n);
        for (int i = 0; i < n * FPS; i++) begin
            cyc(0, 0, 1, 0, 0);
            idle_cyc();
        end
    endtask

    // Scoreboard monitor: pops on each step pulse, and tracks per-cycle state.
    always @(posedge clk) begin
        step_t e;
        #1;
        if (mon_en) begin
            if (step) begin
                if (exp_q.size() == 0) begin
                    check("step_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_head_x", int'(head_x), e.x);
                    check("sb_head_y", int'(head_y), e.y);
                    check("sb_dir", int'(dir), e.d);
                end
            end
            check("cyc_step", int'(step), int'(m_step));
            check("cyc_running", int'(running), int'(m_state == 1));
            check("cyc_dead", int'(dead), int'(m_state == 2));
            check("cyc_head_x", int'(head_x), m_x);
            check("cyc_head_y", int'(head_y), m_y);
            check("cyc_dir", int'(dir), m_dir);
        end
    end

    initial begin
        // T1: reset and ticks without start
        cyc(1, 0, 0, 0, 0);
        check("t1_rst_x", int'(head_x), 16);
        check("t1_rst_y", int'(head_y), 12);
        check("t1_rst_dir", int'(dir), 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 0, 0);
            check("t1_no_step", int'(step), 0);
        end
        check("t1_running", int'(running), 0);
        check("t1_x", int'(head_x), 16);

        // T2: start then 8 ticks
        cyc(0, 1, 0, 0, 0);
        check("t2_running", int'(running), 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1, 0, 0);
            check("t2_step_after_tick", int'(step), int'(i % 4 == 0));
            if (i == 4) check("t2_x4", int'(head_x), 17);
            if (i == 8) check("t2_x8", int'(head_x), 18);
            idle_cyc();
            check("t2_step_width", int'(step), 0);
        end

        // T3: reversal rejected, then turn up
        cyc(0, 0, 0, 1, 3);
        steps(1);
        check("t3_x", int'(head_x), 19);
        cyc(0, 0, 0, 1, 0);
        steps(1);
        check("t3_y", int'(head_y), 11);
        check("t3_dir", int'(dir), 0);

        // T4: down request coinciding with step_due while facing right
        cyc(0, 0, 0, 1, 1);
        steps(1);
        check("t4_pre_dir", int'(dir), 1);
        for (int i = 0; i < FPS - 1; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 2);
        check("t4_x", int'(head_x), 21);
        check("t4_y_hold", int'(head_y), 11);
        steps(1);
        check("t4_down_y", int'(head_y), 12);
        check("t4_down_dir", int'(dir), 2);

        // T5: run into the right wall
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        steps(15);
        check("t5_x31", int'(head_x), 31);
        steps(1);
`ifdef WRAP_EN
        check("t5_wrap_x", int'(head_x), 0);
        check("t5_wrap_dead", int'(dead), 0);
        cyc(1, 0, 0, 0, 0);
`else
        check("t5_dead", int'(dead), 1);
        check("t5_hold_x", int'(head_x), 31);
        check("t5_hold_y", int'(head_y), 12);
`endif
        cyc(0, 1, 0, 0, 0);
        check("t5_restart_x", int'(head_x), 16);
        check("t5_restart_run", int'(running), 1);

        // T6: reset mid-run at (20,5)
        steps(4);
        cyc(0, 0, 0, 1, 0);
        steps(7);
        check("t6_pre_x", int'(head_x), 20);
        check("t6_pre_y", int'(head_y), 5);
        cyc(1, 0, 1, 1, 2);
        check("t6_x", int'(head_x), 16);
        check("t6_y", int'(head_y), 12);
        check("t6_dir", int'(dir), 1);
        check("t6_running", int'(running), 0);
        check("t6_step", int'(step), 0);

        // Random play
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 399) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 5) == 0),
                int'($urandom_range(0, 3)));
        end
        idle_cyc();
        check("sb_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
